// File: rtl/maxpool_layer_scheduler_if.sv
// Control, code and monitor signals between the layer controller, the maxpool
// layer scheduler and the spiking maxpool unit.
interface maxpool_layer_scheduler_if #(
  parameter int unsigned LAYER_NUM = 4
);
  localparam int unsigned IDX_W = $clog2(LAYER_NUM);

  logic             cfg_wr_en;
  logic [IDX_W-1:0] cfg_addr;
  logic [15:0]      cfg_in_ch;
  logic [15:0]      cfg_img_size;
  logic             start;
  logic [3:0]       num_layers;
  logic             abort;
  logic             code_valid;
  logic [15:0]      conv_in_ch;
  logic [15:0]      conv_img_size;
  logic             conv_or_maxpool;
  logic             pool_out_valid;
  logic             pool_out_ready;
  logic             pool_out_done;
  logic             busy;
  logic [IDX_W-1:0] layer_idx;
  logic             layer_done;
  logic             all_done;
  logic             err_count;
  logic             err_timeout;

  modport master (
    output cfg_wr_en, cfg_addr, cfg_in_ch, cfg_img_size, start, num_layers, abort,
    output pool_out_valid, pool_out_ready, pool_out_done,
    input  code_valid, conv_in_ch, conv_img_size, conv_or_maxpool,
    input  busy, layer_idx, layer_done, all_done, err_count, err_timeout
  );

  modport slave (
    input  cfg_wr_en, cfg_addr, cfg_in_ch, cfg_img_size, start, num_layers, abort,
    input  pool_out_valid, pool_out_ready, pool_out_done,
    output code_valid, conv_in_ch, conv_img_size, conv_or_maxpool,
    output busy, layer_idx, layer_done, all_done, err_count, err_timeout
  );
endinterface

// File: rtl/maxpool_layer_scheduler.sv
// Walks a small descriptor table, issuing one maxpool code per layer and
// checking the output beat count and unit activity for each layer.
module maxpool_layer_scheduler #(
  parameter int unsigned LAYER_NUM = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input logic                    s_clk,
  input logic                    s_rst,
  maxpool_layer_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(LAYER_NUM);
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_RUN, S_CHECK, S_ERROR
  } state_t;

  state_t               state;
  logic [15:0]          tbl_in_ch    [LAYER_NUM];
  logic [15:0]          tbl_img_size [LAYER_NUM];
  logic [3:0]           num_lat;
  logic [31:0]          expected;
  logic [31:0]          beat_cnt;
  logic [TIMEOUT_W-1:0] wd;

  logic hs_c;
  logic last_c;
  assign hs_c   = bus.pool_out_valid & bus.pool_out_ready;
  assign last_c = (4'(bus.layer_idx) == (num_lat - 4'd1));

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state               <= S_IDLE;
      num_lat             <= '0;
      expected            <= '0;
      beat_cnt            <= '0;
      wd                  <= '0;
      bus.code_valid      <= 1'b0;
      bus.conv_in_ch      <= '0;
      bus.conv_img_size   <= '0;
      bus.conv_or_maxpool <= 1'b0;
      bus.busy            <= 1'b0;
      bus.layer_idx       <= '0;
      bus.layer_done      <= 1'b0;
      bus.all_done        <= 1'b0;
      bus.err_count       <= 1'b0;
      bus.err_timeout     <= 1'b0;
      for (int i = 0; i < int'(LAYER_NUM); i++) begin
        tbl_in_ch[i]    <= '0;
        tbl_img_size[i] <= '0;
      end
    end else begin
      bus.code_valid <= 1'b0;
      bus.layer_done <= 1'b0;
      bus.all_done   <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        // Cancel: drop activity but keep sticky errors for inspection
        state               <= S_IDLE;
        bus.busy            <= 1'b0;
        bus.conv_or_maxpool <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cfg_wr_en) begin
              tbl_in_ch[bus.cfg_addr]    <= bus.cfg_in_ch;
              tbl_img_size[bus.cfg_addr] <= bus.cfg_img_size;
            end
            if (bus.start) begin
              bus.err_count   <= 1'b0;
              bus.err_timeout <= 1'b0;
              bus.layer_idx   <= '0;
              if (bus.num_layers == 4'd0) begin
                bus.all_done <= 1'b1;
              end else begin
                num_lat  <= (bus.num_layers > 4'(LAYER_NUM)) ? 4'(LAYER_NUM) : bus.num_layers;
                bus.busy <= 1'b1;
                state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            bus.conv_in_ch      <= tbl_in_ch[bus.layer_idx];
            bus.conv_img_size   <= tbl_img_size[bus.layer_idx];
            expected            <= 32'(tbl_in_ch[bus.layer_idx]) *
                                   ((32'(tbl_img_size[bus.layer_idx]) + 32'd1) >> 1);
            beat_cnt            <= '0;
            wd                  <= '0;
            bus.code_valid      <= 1'b1;
            bus.conv_or_maxpool <= 1'b1;
            state               <= S_ISSUE;
          end
          S_ISSUE: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (hs_c) beat_cnt <= beat_cnt + 32'd1;
            // Done takes priority over the watchdog; a coincident beat is still counted
            if (bus.pool_out_done) begin
              bus.conv_or_maxpool <= 1'b0;
              bus.layer_done      <= 1'b1;
              bus.all_done        <= last_c;
              state               <= S_CHECK;
            end else if (hs_c) begin
              wd <= '0;
            end else if (wd == WD_MAX - TIMEOUT_W'(1)) begin
              wd              <= WD_MAX;
              bus.err_timeout <= 1'b1;
              state           <= S_ERROR;
            end else begin
              wd <= wd + TIMEOUT_W'(1);
            end
          end
          S_CHECK: begin
            if (beat_cnt != expected) bus.err_count <= 1'b1;
            if (last_c) begin
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              bus.layer_idx <= bus.layer_idx + IDX_W'(1);
              state         <= S_LOAD;
            end
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maxpool_layer_scheduler.sv
// Directed bench for maxpool_layer_scheduler with a short watchdog so the
// timeout path is reachable quickly.
module tb_maxpool_layer_scheduler;
  logic s_clk = 1'b0;
  logic s_rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   ch [4];
  int   img [4];
  int   beats [4];

  maxpool_layer_scheduler_if #(.LAYER_NUM(4)) bus ();

  maxpool_layer_scheduler #(.LAYER_NUM(4), .TIMEOUT_W(4)) dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  always #5 s_clk = ~s_clk;

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int c, input int i, input int b);
    bus.cfg_wr_en    = 1'b1;
    bus.cfg_addr     = 2'(idx);
    bus.cfg_in_ch    = 16'(c);
    bus.cfg_img_size = 16'(i);
    tick();
    bus.cfg_wr_en = 1'b0;
    ch[idx] = c; img[idx] = i; beats[idx] = b;
  endtask

  // From the ISSUE cycle: drive n beats then done; returns in the CHECK cycle
  task automatic do_layer(input int n, input bit coincide);
    tick();
    for (int i = 0; i < n; i++) begin
      bus.pool_out_valid = 1'b1;
      bus.pool_out_ready = 1'b1;
      if (coincide && i == n - 1) bus.pool_out_done = 1'b1;
      tick();
    end
    bus.pool_out_valid = 1'b0;
    bus.pool_out_ready = 1'b0;
    if (!coincide) begin
      bus.pool_out_done = 1'b1;
      tick();
    end
    bus.pool_out_done = 1'b0;
  endtask

  task automatic wait_code(output int n);
    n = 0;
    while (bus.code_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_list(input int nreq, input int nrun, input int short_idx, input int co_idx);
    int n;
    bit err_exp = 1'b0;
    bus.num_layers = 4'(nreq);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int l = 0; l < nrun; l++) begin
      wait_code(n);
      chk("code_latency", 32'(n), (l == 0) ? 32'd1 : 32'd2);
      chk("layer_idx", 32'(bus.layer_idx), 32'(l));
      chk("conv_in_ch", 32'(bus.conv_in_ch), 32'(ch[l]));
      chk("conv_img_size", 32'(bus.conv_img_size), 32'(img[l]));
      chk("conv_or_maxpool", 32'(bus.conv_or_maxpool), 32'd1);
      chk("err_count_run", 32'(bus.err_count), 32'(err_exp));
      do_layer(beats[l] - ((l == short_idx) ? 1 : 0), l == co_idx);
      if (l == short_idx) err_exp = 1'b1;
      chk("layer_done", 32'(bus.layer_done), 32'd1);
      chk("all_done", 32'(bus.all_done), (l == nrun - 1) ? 32'd1 : 32'd0);
      chk("cm_drop", 32'(bus.conv_or_maxpool), 32'd0);
    end
    tick();
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("all_done_end", 32'(bus.all_done), 32'd0);
    chk("err_count_end", 32'(bus.err_count), 32'(err_exp));
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  initial begin
    int n;
    int acc;
    s_rst = 1'b1;
    bus.cfg_wr_en = 1'b0; bus.cfg_addr = '0; bus.cfg_in_ch = '0; bus.cfg_img_size = '0;
    bus.start = 1'b0; bus.num_layers = '0; bus.abort = 1'b0;
    bus.pool_out_valid = 1'b0; bus.pool_out_ready = 1'b0; bus.pool_out_done = 1'b0;
    for (int i = 0; i < 4; i++) begin ch[i] = 0; img[i] = 0; beats[i] = 0; end
    tick(); tick();
    chk("rst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_conv_or_maxpool", 32'(bus.conv_or_maxpool), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
    s_rst = 1'b0;
    tick();

    // Single layer (2,8): 8 beats
    wr(0, 2, 8, 8);
    run_list(1, 1, -1, -1);

    // Three layers; layer 1's last beat coincides with done
    wr(0, 4, 16, 32); wr(1, 1, 7, 4); wr(2, 8, 32, 128);
    run_list(3, 3, -1, 1);

    // Short layer 0 (7 of 8 beats); list still completes
    wr(0, 2, 8, 8);
    run_list(2, 2, 0, -1);

    // Zero-length start: all_done only, clears err_count
    bus.num_layers = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("zero_all_done", 32'(bus.all_done), 32'd1);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    chk("zero_err_clear", 32'(bus.err_count), 32'd0);
    acc = 0;
    repeat (4) begin tick(); acc += int'(bus.code_valid) + int'(bus.busy); end
    chk("zero_no_code", 32'(acc), 32'd0);

    // Oversized num_layers clamps to 4; entry 3 is empty (0 beats)
    run_list(12, 4, -1, -1);

    // Abort during layer 1 of 3; a write while busy must be ignored
    bus.num_layers = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_code(n);
    do_layer(beats[0], 1'b0);
    wait_code(n);
    chk("abort_layer1_idx", 32'(bus.layer_idx), 32'd1);
    tick();
    bus.pool_out_valid = 1'b1; bus.pool_out_ready = 1'b1;
    bus.cfg_wr_en = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_in_ch = 16'd77; bus.cfg_img_size = 16'd77;
    tick(); tick();
    bus.cfg_wr_en = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0; bus.pool_out_valid = 1'b0; bus.pool_out_ready = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cm", 32'(bus.conv_or_maxpool), 32'd0);
    chk("abort_no_done", 32'(bus.layer_done) + 32'(bus.all_done), 32'd0);
    bus.pool_out_done = 1'b1;
    tick();
    bus.pool_out_done = 1'b0;
    acc = 0;
    repeat (4) begin acc += int'(bus.layer_done) + int'(bus.all_done) + int'(bus.code_valid); tick(); end
    chk("idle_done_ignored", 32'(acc), 32'd0);
    wr(0, 5, 3, 10);
    run_list(2, 2, -1, -1);

    // Asynchronous reset mid-RUN
    bus.num_layers = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.pool_out_valid = 1'b1; bus.pool_out_ready = 1'b1;
    tick();
    #2 s_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_conv_in_ch", 32'(bus.conv_in_ch), 32'd0);
    chk("arst_conv_img_size", 32'(bus.conv_img_size), 32'd0);
    chk("arst_cm", 32'(bus.conv_or_maxpool), 32'd0);
    bus.pool_out_valid = 1'b0; bus.pool_out_ready = 1'b0;
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin ch[i] = 0; img[i] = 0; beats[i] = 0; end
    tick();
    run_list(1, 1, -1, -1);

    // Watchdog: no handshakes after ISSUE, 15 idle cycles
    bus.num_layers = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("to_code_valid", 32'(bus.code_valid), 32'd1);
    repeat (15) tick();
    chk("to_not_yet", 32'(bus.err_timeout), 32'd0);
    tick();
    chk("to_fired", 32'(bus.err_timeout), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd1);
    bus.pool_out_done = 1'b1;
    tick();
    bus.pool_out_done = 1'b0;
    acc = 0;
    repeat (3) begin acc += int'(bus.code_valid) + int'(bus.layer_done); tick(); end
    chk("to_stuck", 32'(acc), 32'd0);
    chk("to_busy_held", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("to_abort_busy", 32'(bus.busy), 32'd0);
    chk("to_sticky", 32'(bus.err_timeout), 32'd1);
    bus.num_layers = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("to_cleared", 32'(bus.err_timeout), 32'd0);
    chk("to_restart_all_done", 32'(bus.all_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
